// File: rtl/text_edit_if.sv
// Key command handshake, VGA fetch port and character RAM port of the text edit controller.
// The master side is the controller; the slave side is its surroundings (keyboard, VGA, RAM).
interface text_edit_if;
    logic       key_valid;
    logic       key_ready;
    logic [1:0] key_code;
    logic [7:0] key_ascii;
    logic [6:0] rd_h;
    logic [4:0] rd_v;
    logic [7:0] rd_data;
    logic [11:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic [6:0] cur_h;
    logic [4:0] cur_v;
    logic [4:0] line_offset;

    modport master (
        input  key_valid, key_code, key_ascii, rd_h, rd_v, mem_rdata,
        output key_ready, rd_data, mem_addr, mem_wdata, mem_we, cur_h, cur_v, line_offset
    );

    modport slave (
        output key_valid, key_code, key_ascii, rd_h, rd_v, mem_rdata,
        input  key_ready, rd_data, mem_addr, mem_wdata, mem_we, cur_h, cur_v, line_offset
    );
endinterface

// File: rtl/text_edit_ctrl.sv
// Character buffer scheduler: even slots serve VGA reads (rd_data 2 cycles later), odd slots edit writes.
// Commands are held off (key_ready low) from capture until the write and any row/screen sweep finish.
module text_edit_ctrl #(
    parameter int COLS     = 70,
    parameter int ROWS     = 30,
    parameter int BUF_ROWS = 32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    text_edit_if.master io_bus
);
    localparam logic [1:0] K_CHAR  = 2'b00;
    localparam logic [1:0] K_BS    = 2'b01;
    localparam logic [1:0] K_ENTER = 2'b10;
    localparam logic [1:0] K_CLEAR = 2'b11;
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [4:0] LAST_BUF = 5'(BUF_ROWS - 1);

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_WRITE, S_CLR_ROW, S_CLR_ALL} state_t;

    state_t      r_state, w_next;
    logic        r_phase;
    logic [6:0]  r_cur_h;
    logic [4:0]  r_cur_v;
    logic [4:0]  r_off;
    logic [7:0]  r_rd_data;
    logic [6:0]  r_le [BUF_ROWS];
    logic [1:0]  r_cmd_code;
    logic [7:0]  r_cmd_ascii;
    logic [11:0] r_wr_addr;
    logic [7:0]  r_wr_dat;
    logic        r_scroll;
    logic [6:0]  r_sw_col;
    logic [4:0]  r_sw_row;

    logic        w_accept;
    logic [4:0]  w_row, w_prev, w_rd_row;
    logic [6:0]  w_prev_le;
    logic        w_exec_nl, w_exec_scroll, w_exec_write, w_sweep_done;

    assign w_accept  = io_bus.key_valid && (r_state == S_IDLE);
    assign w_row     = r_cur_v + r_off;
    assign w_prev    = w_row - 5'd1;
    assign w_prev_le = r_le[w_prev];
    assign w_rd_row  = io_bus.rd_v + r_off;

    assign w_exec_nl     = (r_cmd_code == K_ENTER) || ((r_cmd_code == K_CHAR) && (r_cur_h == LAST_COL));
    assign w_exec_scroll = w_exec_nl && (r_cur_v == LAST_ROW);
    assign w_exec_write  = (r_cmd_code == K_CHAR) ||
                           ((r_cmd_code == K_BS) &&
                            ((r_cur_h != 7'd0) || ((r_cur_v != 5'd0) && (w_prev_le == 7'(COLS)))));
    assign w_sweep_done  = r_phase && (r_sw_col == LAST_COL) &&
                           ((r_state == S_CLR_ROW) || (r_sw_row == LAST_BUF));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_CLR_ALL;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = S_EXEC;
            S_EXEC: begin
                if (r_cmd_code == K_CLEAR) w_next = S_CLR_ALL;
                else if (w_exec_write)     w_next = S_WRITE;
                else if (w_exec_scroll)    w_next = S_CLR_ROW;
                else                       w_next = S_IDLE;
            end
            S_WRITE:   if (r_phase) w_next = r_scroll ? S_CLR_ROW : S_IDLE;
            S_CLR_ROW,
            S_CLR_ALL: if (w_sweep_done) w_next = S_IDLE;
            default:   w_next = S_CLR_ALL;
        endcase
    end

    // Even slots always present the VGA address, so reads never see edit state.
    always_comb begin
        io_bus.key_ready = (r_state == S_IDLE);
        io_bus.mem_addr  = {io_bus.rd_h, w_rd_row};
        io_bus.mem_wdata = 8'h00;
        io_bus.mem_we    = 1'b0;
        if (r_phase) begin
            case (r_state)
                S_WRITE: begin
                    io_bus.mem_addr  = r_wr_addr;
                    io_bus.mem_wdata = r_wr_dat;
                    io_bus.mem_we    = 1'b1;
                end
                S_CLR_ROW, S_CLR_ALL: begin
                    io_bus.mem_addr = {r_sw_col, r_sw_row};
                    io_bus.mem_we   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign io_bus.rd_data     = r_rd_data;
    assign io_bus.cur_h       = r_cur_h;
    assign io_bus.cur_v       = r_cur_v;
    assign io_bus.line_offset = r_off;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_phase     <= 1'b0;
            r_cur_h     <= 7'd0;
            r_cur_v     <= 5'd0;
            r_off       <= 5'd0;
            r_rd_data   <= 8'h00;
            r_cmd_code  <= 2'b00;
            r_cmd_ascii <= 8'h00;
            r_wr_addr   <= 12'd0;
            r_wr_dat    <= 8'h00;
            r_scroll    <= 1'b0;
            r_sw_col    <= 7'd0;
            r_sw_row    <= 5'd0;
            for (int i = 0; i < BUF_ROWS; i++) r_le[i] <= 7'd0;
        end else begin
            r_phase <= ~r_phase;
            if (r_phase) r_rd_data <= io_bus.mem_rdata;
            if (w_accept) begin
                r_cmd_code  <= io_bus.key_code;
                r_cmd_ascii <= io_bus.key_ascii;
            end
            case (r_state)
                S_EXEC: begin
                    r_scroll <= w_exec_scroll;
                    r_wr_dat <= 8'h00;
                    case (r_cmd_code)
                        K_CHAR: begin
                            r_wr_addr <= {r_cur_h, w_row};
                            r_wr_dat  <= r_cmd_ascii;
                            if (r_cur_h == LAST_COL) r_le[w_row] <= 7'(COLS);
                            else                     r_cur_h <= r_cur_h + 7'd1;
                        end
                        K_ENTER: r_le[w_row] <= r_cur_h;
                        K_BS: begin
                            if (r_cur_h != 7'd0) begin
                                r_cur_h   <= r_cur_h - 7'd1;
                                r_wr_addr <= {r_cur_h - 7'd1, w_row};
                            end else if (r_cur_v != 5'd0) begin
                                // A full previous row keeps the cursor on the last column and erases it.
                                r_cur_v   <= r_cur_v - 5'd1;
                                r_cur_h   <= (w_prev_le > LAST_COL) ? LAST_COL : w_prev_le;
                                r_wr_addr <= {LAST_COL, w_prev};
                            end
                        end
                        default: begin
                            r_cur_h  <= 7'd0;
                            r_cur_v  <= 5'd0;
                            r_off    <= 5'd0;
                            r_sw_col <= 7'd0;
                            r_sw_row <= 5'd0;
                        end
                    endcase
                    if (w_exec_nl) begin
                        r_cur_h <= 7'd0;
                        if (r_cur_v != LAST_ROW) begin
                            r_cur_v <= r_cur_v + 5'd1;
                        end else begin
                            // New bottom row is (off+1)+(ROWS-1), modulo the 5-bit row index.
                            r_off    <= r_off + 5'd1;
                            r_sw_row <= r_off + 5'(ROWS);
                            r_sw_col <= 7'd0;
                        end
                    end
                end
                S_CLR_ROW, S_CLR_ALL: begin
                    if (r_phase) begin
                        if (r_sw_col == LAST_COL) begin
                            r_sw_col <= 7'd0;
                            if (r_state == S_CLR_ALL) r_sw_row <= r_sw_row + 5'd1;
                        end else begin
                            r_sw_col <= r_sw_col + 7'd1;
                        end
                    end
                end
                default: ;
            endcase
            if ((r_state == S_CLR_ROW) && w_sweep_done) r_le[r_sw_row] <= 7'd0;
            if (r_state == S_CLR_ALL) begin
                for (int i = 0; i < BUF_ROWS; i++) r_le[i] <= 7'd0;
            end
        end
    end
endmodule
